// File: rtl/sprite_scheduler_pkg.sv
// sprite_scheduler_pkg: shared field selects, FSM encoding and pixel helpers
package sprite_scheduler_pkg;
   localparam logic [1:0] WR_SEL_X     = 2'd0;
   localparam logic [1:0] WR_SEL_Y     = 2'd1;
   localparam logic [1:0] WR_SEL_ANGLE = 2'd2;
   localparam logic [1:0] WR_SEL_EN    = 2'd3;

   typedef enum logic {ST_ACTIVE, ST_COPY} state_t;

   function automatic int opaque_bit(input int pixel_size);
      return pixel_size - 1;
   endfunction
endpackage

// File: rtl/sprite_scheduler_priority_mux.sv
// sprite_priority_mux: picks the lowest-index visible sprite pixel and flags overlaps
module sprite_priority_mux
   import sprite_scheduler_pkg::*;
#(
   parameter int NUM_SPRITES = 4,
   parameter int PIXEL_SIZE  = 16
) (
   input  logic [NUM_SPRITES-1:0]            i_d_en,
   input  logic [NUM_SPRITES-1:0]            i_en,
   input  logic [NUM_SPRITES*PIXEL_SIZE-1:0] i_pixel,
   output logic [NUM_SPRITES-1:0]            o_vis,
   output logic [PIXEL_SIZE-1:0]             o_pixel,
   output logic                              o_any,
   output logic                              o_multi
);
   localparam logic [NUM_SPRITES-1:0] ONE = 1;

   // walk from the highest index down so the lowest visible index wins; clearing the lowest set bit leaves nonzero iff two or more are visible
   always_comb begin
      o_vis   = '0;
      o_pixel = '0;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         o_vis[i] = i_d_en[i] & i_en[i] & i_pixel[i*PIXEL_SIZE + opaque_bit(PIXEL_SIZE)];
         if (o_vis[i]) o_pixel = i_pixel[i*PIXEL_SIZE +: PIXEL_SIZE];
      end
      o_any   = |o_vis;
      o_multi = |(o_vis & (o_vis - ONE));
   end
endmodule

// File: rtl/sprite_scheduler.sv
// sprite_scheduler: double-buffered sprite attributes, vblank commit, priority compositing and collision flags
module sprite_scheduler
   import sprite_scheduler_pkg::*;
#(
   parameter int                    NUM_SPRITES = 4,
   parameter int                    INPUT_WIDTH = 10,
   parameter int                    PIXEL_SIZE  = 16,
   parameter logic [PIXEL_SIZE-1:0] BG_COLOR    = '0
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               frame_sync,
   input  logic                               wr_valid,
   output logic                               wr_ready,
   input  logic [$clog2(NUM_SPRITES)-1:0]     wr_idx,
   input  logic [1:0]                         wr_sel,
   input  logic [INPUT_WIDTH-1:0]             wr_data,
   output logic [NUM_SPRITES*INPUT_WIDTH-1:0] spr_x_pos,
   output logic [NUM_SPRITES*INPUT_WIDTH-1:0] spr_y_pos,
   output logic [NUM_SPRITES*2-1:0]           spr_angle,
   input  logic [NUM_SPRITES-1:0]             spr_d_en,
   input  logic [NUM_SPRITES*PIXEL_SIZE-1:0]  spr_pixel,
   output logic [PIXEL_SIZE-1:0]              pix_out,
   output logic [NUM_SPRITES-1:0]             collision,
   output logic                               busy
);
   localparam int IW = $clog2(NUM_SPRITES);
   localparam logic [IW-1:0] LAST = IW'(NUM_SPRITES - 1);

   logic [NUM_SPRITES-1:0][INPUT_WIDTH-1:0] r_sx, r_sy, r_ax, r_ay;
   logic [NUM_SPRITES-1:0][1:0]             r_sa, r_aa;
   logic [NUM_SPRITES-1:0]                  r_se, r_ae;
   state_t                                  r_state;
   logic [IW-1:0]                           r_cnt;
   logic                                    r_busy, r_wr_ready;
   logic [PIXEL_SIZE-1:0]                   r_pix;
   logic [NUM_SPRITES-1:0]                  r_live, r_coll;
   logic [NUM_SPRITES-1:0]                  w_vis, w_hit;
   logic [PIXEL_SIZE-1:0]                   w_pix;
   logic                                    w_any, w_multi;

   assign spr_x_pos = r_ax;
   assign spr_y_pos = r_ay;
   assign spr_angle = r_aa;
   assign wr_ready  = r_wr_ready;
   assign busy      = r_busy;
   assign pix_out   = r_pix;
   assign collision = r_coll;
   assign w_hit     = w_vis & {NUM_SPRITES{w_multi}};

   sprite_priority_mux #(
      .NUM_SPRITES(NUM_SPRITES),
      .PIXEL_SIZE (PIXEL_SIZE)
   ) u_mux (
      .i_d_en (spr_d_en),
      .i_en   (r_ae),
      .i_pixel(spr_pixel),
      .o_vis  (w_vis),
      .o_pixel(w_pix),
      .o_any  (w_any),
      .o_multi(w_multi)
   );

   // CPU writes land in the shadow set only; accepted writes are blocked during a commit by wr_ready
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sx <= '0;
         r_sy <= '0;
         r_sa <= '0;
         r_se <= '0;
      end else if (wr_valid && r_wr_ready) begin
         if (wr_sel == WR_SEL_X) r_sx[wr_idx] <= wr_data;
         if (wr_sel == WR_SEL_Y) r_sy[wr_idx] <= wr_data;
         if (wr_sel == WR_SEL_ANGLE) r_sa[wr_idx] <= wr_data[1:0];
         if (wr_sel == WR_SEL_EN) r_se[wr_idx] <= wr_data[0];
      end
   end

   // commit FSM: on vblank copy one sprite per cycle shadow->active, ignoring further frame_sync until done
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_ACTIVE;
         r_cnt      <= '0;
         r_busy     <= 1'b0;
         r_wr_ready <= 1'b1;
         r_ax       <= '0;
         r_ay       <= '0;
         r_aa       <= '0;
         r_ae       <= '0;
      end else if (r_state == ST_ACTIVE) begin
         if (frame_sync) begin
            r_state    <= ST_COPY;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_wr_ready <= 1'b0;
         end
      end else begin
         r_ax[r_cnt] <= r_sx[r_cnt];
         r_ay[r_cnt] <= r_sy[r_cnt];
         r_aa[r_cnt] <= r_sa[r_cnt];
         r_ae[r_cnt] <= r_se[r_cnt];
         r_cnt       <= r_cnt + IW'(1);
         if (r_cnt == LAST) begin
            r_state    <= ST_ACTIVE;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_wr_ready <= 1'b1;
         end
      end
   end

   // registered composite pixel plus sticky per-frame collision, latched and cleared at vblank
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pix  <= BG_COLOR;
         r_live <= '0;
         r_coll <= '0;
      end else begin
         r_pix <= w_any ? {1'b0, w_pix[PIXEL_SIZE-2:0]} : BG_COLOR;
         if (frame_sync && r_state == ST_ACTIVE) begin
            r_coll <= r_live | w_hit;
            r_live <= '0;
         end else begin
            r_live <= r_live | w_hit;
         end
      end
   end
endmodule

// File: tb/tb_sprite_scheduler.sv
// tb_sprite_scheduler: directed vectors and commit/collision sequences for sprite_scheduler
module tb_sprite_scheduler;
   logic        clk = 0;
   logic        rst = 1;
   logic        frame_sync = 0;
   logic        wr_valid = 0;
   logic        wr_ready;
   logic [1:0]  wr_idx = 0;
   logic [1:0]  wr_sel = 0;
   logic [9:0]  wr_data = 0;
   logic [39:0] spr_x_pos, spr_y_pos;
   logic [7:0]  spr_angle;
   logic [3:0]  spr_d_en = 0;
   logic [63:0] spr_pixel = 0;
   logic [15:0] pix_out;
   logic [3:0]  collision;
   logic        busy;
   int          total = 0;
   int          bad = 0;

   typedef struct {
      logic [3:0]  d_en;
      logic [63:0] pix;
      logic [15:0] exp;
   } vec_t;
   vec_t tv[6];

   always #5 clk = ~clk;

   sprite_scheduler dut (
      .clk(clk), .rst(rst), .frame_sync(frame_sync),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx), .wr_sel(wr_sel), .wr_data(wr_data),
      .spr_x_pos(spr_x_pos), .spr_y_pos(spr_y_pos), .spr_angle(spr_angle),
      .spr_d_en(spr_d_en), .spr_pixel(spr_pixel),
      .pix_out(pix_out), .collision(collision), .busy(busy)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic wr(input int idx, input int sel, input int data);
      int n = 0;
      wr_valid = 1;
      wr_idx = 2'(idx);
      wr_sel = 2'(sel);
      wr_data = 10'(data);
      while (!wr_ready && n < 20) begin
         tick;
         n++;
      end
      chk("wr_wait", 64'(n < 20), 1);
      tick;
      wr_valid = 0;
   endtask

   task automatic wait_idle;
      int n = 0;
      while (busy && n < 20) begin
         tick;
         n++;
      end
      chk("idle_wait", 64'(n < 20), 1);
   endtask

   task automatic pulse_fs;
      frame_sync = 1;
      tick;
      frame_sync = 0;
   endtask

   initial begin
      int c;
      tv[0] = '{4'b0101, {16'h0000, 16'h8123, 16'h0000, 16'hFFFF}, 16'h7FFF};
      tv[1] = '{4'b0101, {16'h0000, 16'h8123, 16'h0000, 16'h7FFF}, 16'h0123};
      tv[2] = '{4'b0101, {16'h0000, 16'h0123, 16'h0000, 16'h7FFF}, 16'h0000};
      tv[3] = '{4'b0000, {16'h8001, 16'h8002, 16'h8003, 16'h8004}, 16'h0000};
      tv[4] = '{4'b1000, {16'h8ABC, 16'h8002, 16'h8003, 16'h8004}, 16'h0ABC};
      tv[5] = '{4'b1111, {16'h8333, 16'h8222, 16'h9000, 16'h0001}, 16'h1000};

      tick;
      tick;
      rst = 0;
      tick;
      chk("rst_busy", 64'(busy), 0);
      chk("rst_ready", 64'(wr_ready), 1);
      chk("rst_pix", 64'(pix_out), 0);
      chk("rst_coll", 64'(collision), 0);
      chk("rst_x", 64'(spr_x_pos), 0);

      for (int i = 0; i < 4; i++) wr(i, 3, 1);
      wr(1, 0, 100);
      wr(3, 2, 2);
      chk("x1_before_sync", 64'(spr_x_pos[19:10]), 0);

      pulse_fs;
      c = 0;
      while (busy && c < 10) begin
         if (c == 0) chk("copy_ready", 64'(wr_ready), 0);
         if (c == 1) begin
            chk("x1_cnt0", 64'(spr_x_pos[19:10]), 0);
            frame_sync = 1;
         end
         if (c == 2) begin
            frame_sync = 0;
            chk("x1_cnt1", 64'(spr_x_pos[19:10]), 100);
         end
         tick;
         c++;
      end
      chk("busy_len", 64'(c), 4);
      chk("ready_after", 64'(wr_ready), 1);
      chk("angle3", 64'(spr_angle[7:6]), 2);

      pulse_fs;
      wr_valid = 1;
      wr_idx = 2;
      wr_sel = 0;
      wr_data = 7;
      chk("hold_ready0", 64'(wr_ready), 0);
      c = 0;
      while (!wr_ready && c < 20) begin
         tick;
         c++;
      end
      chk("hold_len", 64'(c), 4);
      tick;
      wr_valid = 0;

      wr_valid = 1;
      wr_idx = 0;
      wr_sel = 1;
      wr_data = 50;
      frame_sync = 1;
      tick;
      wr_valid = 0;
      frame_sync = 0;
      tick;
      chk("y0_same_cycle", 64'(spr_y_pos[9:0]), 50);
      wait_idle;
      chk("x2_held", 64'(spr_x_pos[29:20]), 7);

      for (int i = 0; i < 6; i++) begin
         spr_d_en = tv[i].d_en;
         spr_pixel = tv[i].pix;
         tick;
         chk($sformatf("pix_vec%0d", i), 64'(pix_out), 64'(tv[i].exp));
      end
      spr_d_en = 0;
      pulse_fs;
      chk("coll_table", 64'(collision), 4'b1111);
      wait_idle;

      spr_pixel = {16'h8003, 16'h0000, 16'h8001, 16'h8000};
      spr_d_en = 4'b0001;
      tick;
      spr_d_en = 4'b1010;
      tick;
      spr_d_en = 4'b0000;
      tick;
      pulse_fs;
      chk("coll_13", 64'(collision), 4'b1010);
      wait_idle;
      chk("coll_stable", 64'(collision), 4'b1010);
      spr_d_en = 4'b0001;
      tick;
      spr_d_en = 0;
      pulse_fs;
      chk("coll_clear", 64'(collision), 0);
      wait_idle;

      wr(0, 3, 0);
      pulse_fs;
      wait_idle;
      spr_pixel = {16'h0000, 16'h0000, 16'h8222, 16'h8111};
      spr_d_en = 4'b0011;
      tick;
      chk("pix_disabled0", 64'(pix_out), 16'h0222);
      spr_d_en = 0;
      pulse_fs;
      chk("coll_disabled", 64'(collision), 0);
      wait_idle;

      pulse_fs;
      tick;
      rst = 1;
      tick;
      chk("rst_copy_busy", 64'(busy), 0);
      chk("rst_copy_ready", 64'(wr_ready), 1);
      chk("rst_copy_x", 64'(spr_x_pos), 0);
      chk("rst_copy_y", 64'(spr_y_pos), 0);
      chk("rst_copy_ang", 64'(spr_angle), 0);
      chk("rst_copy_pix", 64'(pix_out), 0);
      rst = 0;
      tick;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
